// File: rtl/counter_slot_arbiter.sv
// Shared up-counter lent to NUM_REQ requesters as timed slots: arbitrate, count 0..len, pulse done, release.
// Define COUNTER_SLOT_ARBITER_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module counter_slot_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [NUM_REQ-1:0]            i_req,
    input  logic [NUM_REQ*CNT_WIDTH-1:0]  i_len,
    input  logic                          i_abort,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic [NUM_REQ-1:0]            o_done,
    output logic                          o_busy,
    output logic [CNT_WIDTH-1:0]          o_count
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NUM_REQ-1:0]     r_grant;
    logic [NUM_REQ-1:0]     w_grant_nxt;
    logic [NUM_REQ-1:0]     r_done;
    logic [NUM_REQ-1:0]     w_done_nxt;
    logic                   r_busy;
    logic                   w_busy_nxt;
    logic [CNT_WIDTH-1:0]   r_count;
    logic [CNT_WIDTH-1:0]   w_count_nxt;

    // Slot data: latched at grant, no reset needed because it is only read while a slot is live.
    logic [CNT_WIDTH-1:0]   r_len;
    logic [CNT_WIDTH-1:0]   w_len_nxt;
    logic [NUM_REQ-1:0]     r_owner_oh;
    logic [NUM_REQ-1:0]     w_owner_oh_nxt;

    logic                   w_any;
    logic [PTR_W-1:0]       w_win;
    logic [NUM_REQ-1:0]     w_win_oh;
    logic [CNT_WIDTH-1:0]   w_win_len;

    assign w_any = |i_req;

`ifdef COUNTER_SLOT_ARBITER_FIXED_PRIO_EN
    // Downward scan so the lowest asserted index is written last and wins.
    always_comb begin
        w_win = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                w_win = PTR_W'(i);
            end
        end
    end
`else
    logic [PTR_W-1:0]       r_last;
    logic [PTR_W-1:0]       w_last_nxt;
    logic [PTR_W-1:0]       r_owner;
    logic [PTR_W-1:0]       w_owner_nxt;
    logic                   w_found;
    logic [PTR_W-1:0]       w_scan;

    // Scan last+1 .. last+NUM_REQ (mod NUM_REQ); first asserted index wins.
    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_scan  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_scan = PTR_W'((int'(r_last) + i) % NUM_REQ);
            if (!w_found && i_req[w_scan]) begin
                w_found = 1'b1;
                w_win   = w_scan;
            end
        end
    end
`endif

    always_comb begin
        w_win_oh  = '0;
        w_win_len = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == PTR_W'(i)) begin
                w_win_oh[i] = 1'b1;
                w_win_len   = i_len[i*CNT_WIDTH +: CNT_WIDTH];
            end
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_grant_nxt    = r_grant;
        w_done_nxt     = '0;
        w_busy_nxt     = r_busy;
        w_count_nxt    = r_count;
        w_len_nxt      = r_len;
        w_owner_oh_nxt = r_owner_oh;
`ifndef COUNTER_SLOT_ARBITER_FIXED_PRIO_EN
        w_last_nxt     = r_last;
        w_owner_nxt    = r_owner;
`endif
        case (r_state)
            S_IDLE: begin
                w_count_nxt = '0;
                if (w_any) begin
                    w_state_nxt    = S_RUN;
                    w_grant_nxt    = w_win_oh;
                    w_busy_nxt     = 1'b1;
                    w_len_nxt      = w_win_len;
                    w_owner_oh_nxt = w_win_oh;
`ifndef COUNTER_SLOT_ARBITER_FIXED_PRIO_EN
                    w_owner_nxt    = w_win;
`endif
                end
            end
            S_RUN: begin
                // Abort outranks completion when both land in the same cycle.
                if (i_abort) begin
                    w_state_nxt = S_IDLE;
                    w_grant_nxt = '0;
                    w_busy_nxt  = 1'b0;
                    w_count_nxt = '0;
`ifndef COUNTER_SLOT_ARBITER_FIXED_PRIO_EN
                    w_last_nxt  = r_owner;
`endif
                end else if (r_count == r_len) begin
                    w_state_nxt = S_DONE;
                    w_grant_nxt = '0;
                    w_done_nxt  = r_owner_oh;
                end else begin
                    w_count_nxt = r_count + CNT_WIDTH'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_count_nxt = '0;
`ifndef COUNTER_SLOT_ARBITER_FIXED_PRIO_EN
                w_last_nxt  = r_owner;
`endif
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
                w_count_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_done  <= '0;
            r_busy  <= 1'b0;
            r_count <= '0;
`ifndef COUNTER_SLOT_ARBITER_FIXED_PRIO_EN
            r_last  <= PTR_W'(NUM_REQ - 1);
`endif
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_done  <= w_done_nxt;
            r_busy  <= w_busy_nxt;
            r_count <= w_count_nxt;
`ifndef COUNTER_SLOT_ARBITER_FIXED_PRIO_EN
            r_last  <= w_last_nxt;
`endif
        end
    end

    always_ff @(posedge i_clk) begin
        r_len      <= w_len_nxt;
        r_owner_oh <= w_owner_oh_nxt;
`ifndef COUNTER_SLOT_ARBITER_FIXED_PRIO_EN
        r_owner    <= w_owner_nxt;
`endif
    end

    assign o_grant = r_grant;
    assign o_done  = r_done;
    assign o_busy  = r_busy;
    assign o_count = r_count;

endmodule

// File: tb/tb_counter_slot_arbiter.sv
// Directed bench for counter_slot_arbiter (NUM_REQ=4, CNT_WIDTH=8); checks at the falling edge.
module tb_counter_slot_arbiter;

    localparam int NR = 4;
    localparam int CW = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [NR*CW-1:0]  len = '0;
    logic              abort = 1'b0;
    logic [NR-1:0]     grant;
    logic [NR-1:0]     done;
    logic              busy;
    logic [CW-1:0]     count;

    int n_tests = 0;
    int n_fail  = 0;

    counter_slot_arbiter #(.NUM_REQ(NR), .CNT_WIDTH(CW)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_req   (req),
        .i_len   (len),
        .i_abort (abort),
        .o_grant (grant),
        .o_done  (done),
        .o_busy  (busy),
        .o_count (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_all(input string tag, input logic [3:0] g, input logic [3:0] d,
                             input logic b, input logic [7:0] c);
        check({tag, ".grant"}, 32'(grant), 32'(g));
        check({tag, ".done"},  32'(done),  32'(d));
        check({tag, ".busy"},  32'(busy),  32'(b));
        check({tag, ".count"}, 32'(count), 32'(c));
    endtask

    task automatic set_len(input int k, input logic [7:0] v);
        len[k*CW +: CW] = v;
    endtask

    initial begin
        int exp_idx [5];
        // ---------------- reset state
        tick();
        check_all("reset", 4'b0000, 4'b0000, 1'b0, 8'd0);
        rst = 1'b0;
        tick();
        check_all("idle_noreq", 4'b0000, 4'b0000, 1'b0, 8'd0);

        // ---------------- single request, slice 2 len=3
        set_len(2, 8'd3);
        req = 4'b0100;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_all($sformatf("single.run%0d", i), 4'b0100, 4'b0000, 1'b1, 8'(i));
            req = 4'b0000;
        end
        tick();
        check_all("single.done", 4'b0000, 4'b0100, 1'b1, 8'd3);
        tick();
        check_all("single.idle", 4'b0000, 4'b0000, 1'b0, 8'd0);

        // ---------------- fairness after reset, all len=0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        len = '0;
        req = 4'b1111;
        exp_idx = '{0, 1, 2, 3, 0};
        for (int k = 0; k < 5; k++) begin
            tick();
            check_all($sformatf("fair%0d.run", k), 4'(1 << exp_idx[k]), 4'b0000, 1'b1, 8'd0);
            if (k == 4) req = 4'b0000;
            tick();
            check_all($sformatf("fair%0d.done", k), 4'b0000, 4'(1 << exp_idx[k]), 1'b1, 8'd0);
            tick();
            check_all($sformatf("fair%0d.idle", k), 4'b0000, 4'b0000, 1'b0, 8'd0);
        end

        // ---------------- abort at count 4 (last=0, so index 1 wins first)
        set_len(1, 8'd10);
        set_len(2, 8'd1);
        req = 4'b0110;
        tick();
        check_all("abort.grant", 4'b0010, 4'b0000, 1'b1, 8'd0);
        for (int i = 1; i <= 4; i++) tick();
        check_all("abort.c4", 4'b0010, 4'b0000, 1'b1, 8'd4);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_all("abort.idle", 4'b0000, 4'b0000, 1'b0, 8'd0);
        tick();
        check_all("abort.next", 4'b0100, 4'b0000, 1'b1, 8'd0);
        req = 4'b0000;
        tick();
        check_all("abort.next1", 4'b0100, 4'b0000, 1'b1, 8'd1);
        tick();
        check_all("abort.nextdone", 4'b0000, 4'b0100, 1'b1, 8'd1);
        tick();
        check_all("abort.nextidle", 4'b0000, 4'b0000, 1'b0, 8'd0);

        // ---------------- abort coincident with count==len
        set_len(3, 8'd2);
        req = 4'b1000;
        tick();
        check_all("coinc.grant", 4'b1000, 4'b0000, 1'b1, 8'd0);
        req = 4'b0000;
        tick();
        tick();
        check_all("coinc.c2", 4'b1000, 4'b0000, 1'b1, 8'd2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_all("coinc.idle", 4'b0000, 4'b0000, 1'b0, 8'd0);
        tick();
        check_all("coinc.nodone", 4'b0000, 4'b0000, 1'b0, 8'd0);

        // ---------------- move pointer to 1 so a missing pointer reset would show
        set_len(1, 8'd0);
        req = 4'b0010;
        tick();
        check_all("ptr.grant", 4'b0010, 4'b0000, 1'b1, 8'd0);
        req = 4'b0000;
        tick();
        tick();

        // ---------------- mid-slot asynchronous reset
        set_len(2, 8'd10);
        set_len(0, 8'd0);
        req = 4'b0100;
        tick();
        check_all("mrst.grant", 4'b0100, 4'b0000, 1'b1, 8'd0);
        req = 4'b0000;
        for (int i = 1; i <= 5; i++) tick();
        check_all("mrst.c5", 4'b0100, 4'b0000, 1'b1, 8'd5);
        #2 rst = 1'b1;
        #1 check_all("mrst.async", 4'b0000, 4'b0000, 1'b0, 8'd0);
        req = 4'b1001;
        tick();
        rst = 1'b0;
        tick();
        check_all("mrst.regrant", 4'b0001, 4'b0000, 1'b1, 8'd0);
        req = 4'b0000;
        tick();
        check_all("mrst.done", 4'b0000, 4'b0001, 1'b1, 8'd0);
        tick();

        // ---------------- maximum length 255, no wrap, 256-cycle grant
        set_len(0, 8'd255);
        req = 4'b0001;
        tick();
        check_all("max.grant", 4'b0001, 4'b0000, 1'b1, 8'd0);
        req = 4'b0000;
        for (int i = 1; i <= 255; i++) begin
            tick();
            check($sformatf("max.count%0d", i), 32'(count), 32'(i));
            check($sformatf("max.grant%0d", i), 32'(grant), 32'h1);
        end
        tick();
        check_all("max.done", 4'b0000, 4'b0001, 1'b1, 8'd255);
        tick();
        check_all("max.idle", 4'b0000, 4'b0000, 1'b0, 8'd0);

        // ---------------- i_req=0011 held, len=0 (pointer is 0 here)
`ifdef COUNTER_SLOT_ARBITER_FIXED_PRIO_EN
        exp_idx = '{0, 0, 0, 0, 0};
`else
        exp_idx = '{1, 0, 1, 0, 1};
`endif
        len = '0;
        req = 4'b0011;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("prio%0d.grant", k), 32'(grant), 32'(1 << exp_idx[k]));
            if (k == 3) req = 4'b0000;
            tick();
            check($sformatf("prio%0d.done", k), 32'(done), 32'(1 << exp_idx[k]));
            tick();
        end
        check_all("prio.idle", 4'b0000, 4'b0000, 1'b0, 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_slot_arbiter.md
Name: counter_slot_arbiter

Overview:
- Owns one shared up-counter and lends it to NUM_REQ requesters as a timed "slot".
- Each requester asks for a count length. The block arbitrates among requesters, grants one, and counts from 0 to that length. It then pulses done to the owner and releases the counter.
- Sits between the timing clients and the counter datapath. It is the only sequencer of that counter.

Parameters:
- NUM_REQ, 4: number of requesters; must be ≥2.
- CNT_WIDTH, 8: counter and length width in bits.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_req  in  NUM_REQ  per-requester request level; hold high until granted.
- i_len  in  NUM_REQ*CNT_WIDTH  flattened lengths; slice k = i_len[k*CNT_WIDTH +: CNT_WIDTH].
- i_abort  in  1  terminates the current slot early.
- o_grant  out  NUM_REQ  one-hot owner; all zero when no owner.
- o_done  out  NUM_REQ  one-cycle completion pulse to the owner.
- o_busy  out  1  high whenever state is not IDLE.
- o_count  out  CNT_WIDTH  current shared counter value.

Behaviour:
- Interface: reset i_reset, asynchronous, active-high; clock i_clk.
- Reset values: state IDLE; o_grant=0, o_done=0, o_busy=0, o_count=0. Round-robin pointer last=NUM_REQ-1, so index 0 has top priority after reset. All outputs are registered.
- States: IDLE, RUN, DONE.
- IDLE, i_req==0: stay in IDLE, o_count holds 0.
- IDLE, i_req!=0: at the next edge, pick the winner w and go to RUN.
  - Winner is the first asserted index scanning last+1, last+2, … modulo NUM_REQ.
  - Set o_grant=1<<w, latch len=i_len slice w, set o_count=0.
- RUN, o_count==len: go to DONE at the next edge. o_count holds its value; the counter never wraps.
- RUN, otherwise: o_count increments by 1 each edge.
- DONE: lasts one cycle.
  - During it: o_done=1<<w, o_grant=0, o_count holds len.
  - At the next edge: go to IDLE, o_count←0, last←w.
- Slot timing: the grant is high for exactly len+1 cycles. o_done fires on the cycle after the grant drops. The earliest next grant comes 2 cycles after the done cycle (DONE→IDLE→RUN).
- Only the level in the IDLE cycle is sampled, and len is latched at grant. Changes to i_req or i_len during RUN or DONE are ignored for the active slot.
- len=0: one RUN cycle with o_count=0, then DONE.
- i_abort in RUN: at the next edge go to IDLE.
  - o_grant←0, o_count←0, last←w.
  - No o_done pulse.
  - i_abort has priority over the o_count==len completion in the same cycle.
- i_abort in IDLE or DONE: ignored.
- Reset asserted mid-RUN or mid-DONE: all outputs go to their reset values immediately, with no done pulse. The pointer returns to NUM_REQ-1.

Optional Feature:
- Macro: COUNTER_SLOT_ARBITER_FIXED_PRIO_EN.
- Defined: fixed priority. The lowest asserted index always wins, and the pointer is unused or removed.
- Undefined (default): round-robin as specified above.
- All other timing is identical in both builds.

Test Plan:
- Single request, round-robin build. Reset, then i_req=4'b0100 with slice 2 len=3.
  → o_grant=0100 for 4 cycles with o_count 0,1,2,3.
  → Next cycle o_done=0100, o_grant=0, o_count=3.
  → Then IDLE with o_busy=0 and o_count=0.
- Fairness. i_req=4'b1111 held, all len=0.
  → Grant order 0,1,2,3,0.
  → Each grant lasts 1 cycle; grants repeat every 3 cycles.
- Abort. i_req=4'b0110, slice 1 len=10, i_abort pulsed when o_count=4.
  → Next cycle o_grant=0, o_busy=0, o_count=0, no o_done.
  → The following grant goes to index 2.
- Abort coincident with o_count==len (len=2, abort at o_count=2).
  → Returns to IDLE with no o_done.
- Mid-slot reset. Reset asserted at o_count=5 while index 2 owns the counter.
  → All outputs 0 asynchronously.
  → After release with i_req=4'b1001, index 0 is granted first.
- Max length and fixed priority.
  - CNT_WIDTH=8, len=255: o_count reaches 255 without wrap, and the grant lasts 256 cycles.
  - With COUNTER_SLOT_ARBITER_FIXED_PRIO_EN and i_req=4'b0011 held: every grant goes to index 0.
